pe_result_collector: RTL
========================

# pe_result_collector

Downstream drain stage for the Nanci sorting mesh. Samples the `{addr,data}` word driven on `o_PE` of an edge PE once per compute phase and discards `MAX_INT` sentinel words. Buffers the remaining words in a small FIFO and hands them to the host side over a valid/ready handshake. Flags data-order violations and FIFO overflow so the bench and the host can confirm the mesh actually sorted.

## Interface
- `ADDR_WIDTH`, 3: width of the address field, which is the upper bits of a word.
- `DATA_WIDTH`, 3: width of the data field, which is the lower bits of a word.
- `MAX_INT`, all ones (`{ADDR_WIDTH+DATA_WIDTH{1'b1}}`): empty-slot sentinel, never buffered.
- `N`, 4: number of phase samples taken per collection run.
- `COMPUTE_CYCLES`, 1: clock cycles per compute phase; must be ≥ 1.
- `FIFO_DEPTH`, 4: buffer entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- `i_PE`  in  ADDR_WIDTH+DATA_WIDTH  word from the upstream PE's `o_PE`.
- `o_data`  out  ADDR_WIDTH+DATA_WIDTH  FIFO head word.
- `o_valid`  out  1  FIFO not empty.
- `i_ready`  in  1  consumer accepts `o_data` when `o_valid && i_ready`.
- `o_count`  out  $clog2(N+1)  number of words pushed in the current run.
- `o_unsorted`  out  1  sticky order-violation flag.
- `o_overflow`  out  1  sticky dropped-word flag.
- `o_busy`  out  1  high in COLLECT or DRAIN.
- `o_done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - `i_start=1` moves the block to COLLECT.
  - On that same edge, `o_count`, `o_unsorted`, `o_overflow`, the phase counter and the sample counter are all cleared.
  - FIFO contents are kept.
- COLLECT:
  - The phase counter runs 0..COMPUTE_CYCLES-1 and wraps.
  - When the phase counter reaches COMPUTE_CYCLES-1, `i_PE` is sampled and the sample counter increments.
  - A sample is pushed unless it equals `MAX_INT`.
  - After the N-th sample, the block moves to DRAIN.
- DRAIN: stays until the FIFO is empty (after any pop in that cycle), then moves to DONE.
- DONE: `o_done=1` for exactly one cycle, then the block returns to IDLE.
- Push rules:
  - On a push, `o_count` increments, saturating at N.
  - If this is not the first push of the run and the data field `i_PE[DATA_WIDTH-1:0]` is less than the previous pushed data field, `o_unsorted` is set. Equal values are legal.
  - Push when the FIFO is full and no pop occurs in the same cycle: the word is dropped, `o_overflow` is set, and `o_count` still increments.
  - Push and pop in the same cycle while full: both proceed and there is no overflow.
- Pops are accepted in any state, including IDLE. FIFO pointers wrap modulo FIFO_DEPTH.
- `i_start` outside IDLE is ignored.
- Reset while `rst` is low: FIFO is emptied, state returns to IDLE, and all counters and flags are cleared.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_count`=0, `o_unsorted`=0, `o_overflow`=0, `o_busy`=0, `o_done`=0.
- `i_start` registered at edge t: COLLECT starts in cycle t+1, and `o_busy` rises in t+1.
- First sample edge:
  - With COMPUTE_CYCLES=1, `i_PE` is sampled at the first edge in COLLECT and at every edge after that.
  - In general, sample k (k=1..N) is taken at edge t + k·COMPUTE_CYCLES.
- Push-to-output latency: a word pushed at edge e appears with `o_valid=1` in the cycle after e.
- `o_data` is read directly from the FIFO head (no fall-through bypass).
- `o_valid` and `o_data` hold stable while `i_ready=0`.
- Pop takes effect at the edge where `o_valid && i_ready`.
- After the last sample, the minimum run end is: DRAIN for one cycle, then DONE (`o_done` high) in the following cycle.

## Test plan
- Reset: hold `rst=0` while driving toggling inputs → every output 0; after release with no `i_start`, outputs stay 0.
- Sorted run (defaults, `i_ready=1`):
  - Stimulus: `i_start`, then `i_PE` = 6'b000_001, 001_010, 010_011, 011_100 on consecutive cycles.
  - Required: `o_data` emits the same four words in order, one cycle after each sample.
  - Required: `o_count`=4, `o_unsorted`=0, `o_overflow`=0, one `o_done` pulse.
- Sentinel: samples 000_001, 111_111, 010_011, 011_100 → only three words emitted, `o_count`=3.
- Order violation: data fields 3, 1, 5, 6 → `o_unsorted`=1 from the second push onward; it stays set through DONE and is cleared by the next `i_start`.
- Overflow and backpressure:
  - Setup: FIFO_DEPTH=2, `i_ready=0`, four non-sentinel words.
  - Required: `o_overflow`=1; the first two words are retained; block stays in DRAIN (`o_busy`=1) until `i_ready=1`; those two words are popped in order; then `o_done` pulses.
- Mid-run reset: assert `rst=0` after two samples → outputs return to reset values immediately; a fresh run after release behaves as in the sorted-run scenario.

Source files
------------

// File: rtl/pe_result_collector.sv
// pe_result_collector: samples an edge PE once per compute phase, drops MAX_INT sentinels,
// buffers the rest in a FIFO for a valid/ready consumer and flags order violations and overflow.
module pe_result_collector #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1,
  parameter int N = 4,
  parameter int COMPUTE_CYCLES = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [$clog2(N+1)-1:0]           o_count,
  output logic                             o_unsorted,
  output logic                             o_overflow,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam int PW = COMPUTE_CYCLES > 1 ? $clog2(COMPUTE_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] samp_q, samp_d, cnt_q, cnt_d;
  logic uns_q, uns_d, ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] fill_q, fill_d;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic sample, push_req, pop, full, wr_en;
  assign sample   = state_q == COLLECT && phase_q == PW'(COMPUTE_CYCLES - 1);
  assign push_req = sample && i_PE != MAX_INT;
  assign o_valid  = fill_q != '0;
  assign pop      = o_valid && i_ready;
  assign full     = fill_q == (AW+1)'(FIFO_DEPTH);
  assign wr_en    = push_req && (!full || pop);
  // Gate the head so stale entries never show once the FIFO is empty.
  assign o_data     = o_valid ? mem[rd_q] : '0;
  assign o_count    = cnt_q;
  assign o_unsorted = uns_q;
  assign o_overflow = ovf_q;
  assign o_busy     = state_q == COLLECT || state_q == DRAIN;
  assign o_done     = state_q == DONE;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    uns_d   = uns_q;
    ovf_d   = ovf_q;
    prev_d  = prev_q;
    wr_d    = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    fill_d  = fill_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
    case (state_q)
      IDLE: if (i_start) begin
        state_d = COLLECT;
        phase_d = '0;
        samp_d  = '0;
        cnt_d   = '0;
        uns_d   = 1'b0;
        ovf_d   = 1'b0;
      end
      COLLECT: begin
        phase_d = phase_q == PW'(COMPUTE_CYCLES - 1) ? '0 : phase_q + 1'b1;
        if (sample) begin
          samp_d  = samp_q + 1'b1;
          state_d = samp_q == CW'(N - 1) ? DRAIN : COLLECT;
        end
        if (push_req) begin
          cnt_d  = cnt_q == CW'(N) ? cnt_q : cnt_q + 1'b1;
          prev_d = i_PE[DATA_WIDTH-1:0];
          uns_d  = uns_q || (cnt_q != '0 && i_PE[DATA_WIDTH-1:0] < prev_q);
          ovf_d  = ovf_q || (full && !pop);
        end
      end
      DRAIN:   state_d = fill_d == '0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      samp_q  <= '0;
      cnt_q   <= '0;
      uns_q   <= 1'b0;
      ovf_q   <= 1'b0;
      prev_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      uns_q   <= uns_d;
      ovf_q   <= ovf_d;
      prev_q  <= prev_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= i_PE;
  end
endmodule
